flit_injector: RTL and testbench

//  Network-interface transmitter feeding a router input port. Accepts whole packets, splits them into
//  32-bit flits and stamps each flit with the header fields the router arbiters rank on: golden flag,

---
 rtl/noc_pkg.sv | 43 ++++
 rtl/flit_injector_if.sv | 29 ++
 rtl/golden_epoch.sv | 37 +++
 rtl/flit_injector.sv | 125 ++++++++++++
 tb/tb_flit_injector.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Flit format and shared types for the injector, arbiter and ejector.
// Layout: [31:16] payload, [15] golden, [14:8] packet id, [7:4] dest, [3:0] seq.
package noc_pkg;

   localparam int FLIT_W      = 32;
   localparam int PAYLOAD_LSB = 16;
   localparam int PAYLOAD_W   = 16;
   localparam int GOLD_BIT    = 15;
   localparam int PID_LSB     = 8;
   localparam int PID_W       = 7;
   localparam int DEST_LSB    = 4;
   localparam int DEST_W      = 4;
   localparam int SEQ_LSB     = 0;
   localparam int SEQ_W       = 4;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic                 gold;
      logic [PID_W-1:0]     pid;
      logic [DEST_W-1:0]    dest;
      logic [SEQ_W-1:0]     seq;
   } flit_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } inj_state_e;

   function automatic flit_t make_flit(input logic [PAYLOAD_W-1:0] payload,
                                       input logic                 gold,
                                       input logic [PID_W-1:0]     pid,
                                       input logic [DEST_W-1:0]    dest,
                                       input logic [SEQ_W-1:0]     seq);
      flit_t f;
      f.payload = payload;
      f.gold    = gold;
      f.pid     = pid;
      f.dest    = dest;
      f.seq     = seq;
      return f;
   endfunction

endpackage

// File: rtl/flit_injector_if.sv
// Packet-in / flit-out bundle of the injector. Both channels use valid/ready:
// a beat transfers on a rising edge where valid and ready are both high; valid never drops before that.
interface flit_injector_if #(
   parameter int MAX_FLITS = 8
) ();

   logic                   pkt_valid;
   logic                   pkt_ready;
   logic [4:0]             pkt_len;
   logic [3:0]             pkt_dest;
   logic [16*MAX_FLITS-1:0] pkt_data;
   logic                   flit_valid;
   logic                   flit_ready;
   logic [31:0]            flit_out;
   logic                   len_err;

   // Upstream NI logic / router side driving the injector.
   modport master (
      output pkt_valid, pkt_len, pkt_dest, pkt_data, flit_ready,
      input  pkt_ready, flit_valid, flit_out, len_err
   );

   // The injector itself.
   modport slave (
      input  pkt_valid, pkt_len, pkt_dest, pkt_data, flit_ready,
      output pkt_ready, flit_valid, flit_out, len_err
   );

endinterface

// File: rtl/golden_epoch.sv
// Free-running epoch counter; golden_pid advances on every epoch wrap so that
// every node instantiating this block agrees on which packet id is golden.
module golden_epoch
   import noc_pkg::*;
#(
   parameter int EPOCH_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   output logic [PID_W-1:0] golden_pid_o
);

   localparam int CNT_W = $clog2(EPOCH_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PID_W-1:0] gpid_q, gpid_d;
   logic             wrap;

   always_comb begin
      wrap   = (cnt_q == CNT_W'(EPOCH_CYCLES - 1));
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      gpid_d = wrap ? gpid_q + PID_W'(1) : gpid_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         gpid_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         gpid_q <= gpid_d;
      end
   end

   assign golden_pid_o = gpid_q;

endmodule

// File: rtl/flit_injector.sv
// Network-interface transmitter: takes a whole packet, then streams it as
// stamped 32-bit flits at one flit per cycle into a router input port.
module flit_injector
   import noc_pkg::*;
#(
   parameter int MAX_FLITS    = 8,
   parameter int EPOCH_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   flit_injector_if.slave   io,
   output inj_state_e       dbg_state_o
);

   localparam int DEPTH = 1 << SEQ_W;

   inj_state_e          state_q, state_d;
   logic [PAYLOAD_W-1:0] data_q [DEPTH];
   logic [PAYLOAD_W-1:0] data_d [DEPTH];
   logic [4:0]          len_q, len_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic                gold_q, gold_d;
   logic [PID_W-1:0]    pid_q, pid_d;
   logic [SEQ_W-1:0]    seq_q, seq_d;
   logic                fv_q, fv_d;
   flit_t               flit_q, flit_d;
   logic                len_err_q, len_err_d;
   logic [PID_W-1:0]    golden_pid;
   logic                len_ok;
   logic                last_flit;

   golden_epoch #(
      .EPOCH_CYCLES (EPOCH_CYCLES)
   ) u_epoch (
      .clk          (clk),
      .rst          (rst),
      .golden_pid_o (golden_pid)
   );

   always_comb begin
      len_ok    = (io.pkt_len != 5'd0) && (io.pkt_len <= 5'(MAX_FLITS));
      last_flit = ({1'b0, seq_q} == (len_q - 5'd1));

      state_d   = state_q;
      data_d    = data_q;
      len_d     = len_q;
      dest_d    = dest_q;
      gold_d    = gold_q;
      pid_d     = pid_q;
      seq_d     = seq_q;
      fv_d      = fv_q;
      flit_d    = flit_q;
      len_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (io.pkt_valid) begin
               if (len_ok) begin
                  for (int k = 0; k < MAX_FLITS; k++) begin
                     data_d[k] = io.pkt_data[16*k +: 16];
                  end
                  len_d   = io.pkt_len;
                  dest_d  = io.pkt_dest;
                  gold_d  = (pid_q == golden_pid);
                  seq_d   = '0;
                  flit_d  = make_flit(io.pkt_data[15:0], gold_d, pid_q, io.pkt_dest, '0);
                  fv_d    = 1'b1;
                  state_d = ST_SEND;
               end else begin
                  // Illegal length: the packet is swallowed, only the error pulse remains.
                  len_err_d = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (fv_q && io.flit_ready) begin
               if (last_flit) begin
                  fv_d    = 1'b0;
                  pid_d   = pid_q + PID_W'(1);
                  state_d = ST_IDLE;
               end else begin
                  seq_d  = seq_q + SEQ_W'(1);
                  flit_d = make_flit(data_q[seq_d], gold_q, pid_q, dest_q, seq_d);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
         len_q     <= '0;
         dest_q    <= '0;
         gold_q    <= 1'b0;
         pid_q     <= '0;
         seq_q     <= '0;
         fv_q      <= 1'b0;
         flit_q    <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         len_q     <= len_d;
         dest_q    <= dest_d;
         gold_q    <= gold_d;
         pid_q     <= pid_d;
         seq_q     <= seq_d;
         fv_q      <= fv_d;
         flit_q    <= flit_d;
         len_err_q <= len_err_d;
      end
   end

   assign io.pkt_ready  = (state_q == ST_IDLE);
   assign io.flit_valid = fv_q;
   assign io.flit_out   = flit_q;
   assign io.len_err    = len_err_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_flit_injector.sv
// Bench for flit_injector: scenario tasks plus a negedge scoreboard that predicts
// every flit (with its golden bit from an epoch model) at packet capture.
module tb_flit_injector;
   import noc_pkg::*;

   localparam int MAXF  = 8;
   localparam int EPOCH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   inj_state_e dbg_state;

   flit_injector_if #(.MAX_FLITS(MAXF)) bus ();

   flit_injector #(
      .MAX_FLITS    (MAXF),
      .EPOCH_CYCLES (EPOCH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .io          (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [32:0] exp_q[$];     // {last, flit}
   logic [6:0]  m_pid = '0;
   logic [6:0]  m_gp  = '0;
   logic [1:0]  m_cnt = '0;
   logic        exp_len_err = 1'b0;
   logic        prev_stall  = 1'b0;
   logic [31:0] prev_flit   = '0;

   // Golden epoch model
   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= '0;
         m_gp  <= '0;
      end else if (m_cnt == 2'(EPOCH - 1)) begin
         m_cnt <= '0;
         m_gp  <= m_gp + 7'd1;
      end else begin
         m_cnt <= m_cnt + 2'd1;
      end
   end

   // Scoreboard: decisions for the upcoming edge are taken from values stable at negedge.
   always @(negedge clk) begin
      logic [32:0] e;
      logic        g;
      if (rst) begin
         exp_q.delete();
         m_pid       = '0;
         exp_len_err = 1'b0;
         prev_stall  = 1'b0;
      end else begin
         n_cmp++;
         if (bus.len_err !== exp_len_err) begin
            n_fail++;
            $display("FAIL sb_len_err: got %b want %b @%0t", bus.len_err, exp_len_err, $time);
         end
         exp_len_err = 1'b0;
         if (prev_stall) begin
            n_cmp++;
            if (bus.flit_valid !== 1'b1 || bus.flit_out !== prev_flit) begin
               n_fail++;
               $display("FAIL sb_stall_hold: got v=%b %h want v=1 %h @%0t",
                        bus.flit_valid, bus.flit_out, prev_flit, $time);
            end
         end
         if (bus.flit_valid === 1'b1 && exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_spurious_flit: got %h want none @%0t", bus.flit_out, $time);
         end else if (bus.flit_valid === 1'b1 && bus.flit_ready === 1'b1) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.flit_out !== e[31:0]) begin
               n_fail++;
               $display("FAIL sb_flit: got %h want %h @%0t", bus.flit_out, e[31:0], $time);
            end
            if (e[32]) m_pid = m_pid + 7'd1;
         end
         if (bus.pkt_valid === 1'b1 && bus.pkt_ready === 1'b1) begin
            if (bus.pkt_len != 0 && bus.pkt_len <= MAXF) begin
               g = (m_pid == m_gp);
               for (int k = 0; k < int'(bus.pkt_len); k++) begin
                  e = {(k == int'(bus.pkt_len) - 1), bus.pkt_data[16*k +: 16], g, m_pid,
                       bus.pkt_dest, 4'(k)};
                  exp_q.push_back(e);
               end
            end else begin
               exp_len_err = 1'b1;
            end
         end
         prev_stall = (bus.flit_valid === 1'b1) && (bus.flit_ready !== 1'b1);
         prev_flit  = bus.flit_out;
      end
   end

   function automatic logic [127:0] rand_data();
      logic [127:0] d;
      for (int k = 0; k < 4; k++) d[32*k +: 32] = $urandom;
      return d;
   endfunction

   // Offers one packet; returns 1 time unit after the capture edge.
   task automatic send_pkt(input logic [4:0] len, input logic [3:0] dest, input logic [127:0] data);
      int t = 0;
      while (bus.pkt_ready !== 1'b1 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (bus.pkt_ready !== 1'b1) begin
         n_cmp++;
         n_fail++;
         $display("FAIL pkt_ready_timeout: got %b want 1", bus.pkt_ready);
      end
      bus.pkt_valid = 1'b1;
      bus.pkt_len   = len;
      bus.pkt_dest  = dest;
      bus.pkt_data  = data;
      @(posedge clk); #1;
      bus.pkt_valid = 1'b0;
      bus.pkt_len   = 5'($urandom_range(0, 31));
      bus.pkt_data  = rand_data();
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || bus.pkt_ready !== 1'b1) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || bus.pkt_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending, ready=%b want 0 pending, ready=1",
                  exp_q.size(), bus.pkt_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.pkt_valid  = 1'b0;
      bus.flit_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.pkt_ready !== 1'b1 || bus.flit_valid !== 1'b0 || bus.flit_out !== 32'h0 ||
          bus.len_err !== 1'b0 || dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b v=%b out=%h err=%b st=%0d want 1 0 0 0 0",
                  bus.pkt_ready, bus.flit_valid, bus.flit_out, bus.len_err, dbg_state);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [127:0] d = rand_data();
      bus.flit_ready = 1'b1;
      send_pkt(5'd3, 4'hC, d);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.flit_valid !== 1'b1 || bus.flit_out !== {d[16*i +: 16], 1'b1, 7'd0, 4'hC, 4'(i)}) begin
            n_fail++;
            $display("FAIL basic_flit%0d: got v=%b %h want v=1 %h", i, bus.flit_valid,
                     bus.flit_out, {d[16*i +: 16], 1'b1, 7'd0, 4'hC, 4'(i)});
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.pkt_ready !== 1'b1 || bus.flit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_ready_back: got rdy=%b v=%b want 1 0", bus.pkt_ready, bus.flit_valid);
      end
   endtask

   task automatic test_stall();
      logic [31:0] f;
      wait_idle();
      send_pkt(5'd3, 4'hC, rand_data());
      @(posedge clk); #1;
      bus.flit_ready = 1'b0;
      f = bus.flit_out;
      n_cmp++;
      if (bus.flit_valid !== 1'b1 || f[3:0] !== 4'd1) begin
         n_fail++;
         $display("FAIL stall_seq1: got v=%b seq=%0d want 1 1", bus.flit_valid, f[3:0]);
      end
      repeat (3) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.flit_valid !== 1'b1 || bus.flit_out !== f) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b %h want 1 %h", bus.flit_valid, bus.flit_out, f);
         end
      end
      bus.flit_ready = 1'b1;
      wait_idle();
   endtask

   task automatic test_len_err();
      logic [6:0] pid0 = m_pid;
      logic [4:0] bad[2] = '{5'd0, 5'd9};
      for (int i = 0; i < 2; i++) begin
         wait_idle();
         send_pkt(bad[i], 4'h3, rand_data());
         n_cmp++;
         if (bus.len_err !== 1'b1 || bus.flit_valid !== 1'b0 || bus.pkt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len_err_pulse%0d: got err=%b v=%b rdy=%b want 1 0 1", i,
                     bus.len_err, bus.flit_valid, bus.pkt_ready);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (bus.len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_err_once%0d: got %b want 0", i, bus.len_err);
         end
      end
      send_pkt(5'd1, 4'h5, rand_data());
      n_cmp++;
      if (bus.flit_out[14:8] !== pid0) begin
         n_fail++;
         $display("FAIL len_err_pid: got %0d want %0d", bus.flit_out[14:8], pid0);
      end
      wait_idle();
   endtask

   task automatic test_epoch_cross();
      int   t = 0;
      logic g0, exp_g;
      wait_idle();
      while (m_cnt != 2'(EPOCH - 1) && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      exp_g = (m_pid == m_gp);
      send_pkt(5'd8, 4'h9, rand_data());
      g0 = bus.flit_out[15];
      n_cmp++;
      if (g0 !== exp_g) begin
         n_fail++;
         $display("FAIL epoch_gold: got %b want %b", g0, exp_g);
      end
      for (int i = 1; i < 8; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.flit_out[15] !== g0 || bus.flit_out[3:0] !== 4'(i)) begin
            n_fail++;
            $display("FAIL epoch_gold_const%0d: got g=%b seq=%0d want g=%b seq=%0d", i,
                     bus.flit_out[15], bus.flit_out[3:0], g0, i);
         end
      end
      wait_idle();
      send_pkt(5'd1, 4'h1, rand_data());
      wait_idle();
   endtask

   task automatic test_back_to_back();
      for (int p = 0; p < 6; p++) begin
         int t = 0;
         bus.flit_ready = 1'b1;
         send_pkt(5'($urandom_range(1, MAXF)), 4'($urandom_range(0, 15)), rand_data());
         while (bus.pkt_ready !== 1'b1 && t < 200) begin
            bus.flit_ready = 1'($urandom_range(0, 1));
            bus.pkt_valid  = 1'b1;
            bus.pkt_len    = 5'($urandom_range(0, 31));
            bus.pkt_data   = rand_data();
            @(posedge clk); #1;
            t++;
         end
         bus.pkt_valid = 1'b0;
      end
      bus.flit_ready = 1'b1;
      wait_idle();
   endtask

   task automatic test_reset_mid_packet();
      wait_idle();
      send_pkt(5'd5, 4'h7, rand_data());
      repeat (2) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.flit_out[3:0] !== 4'd2) begin
         n_fail++;
         $display("FAIL abort_seq2: got %0d want 2", bus.flit_out[3:0]);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.flit_valid !== 1'b0 || bus.pkt_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL abort_state: got v=%b rdy=%b st=%0d want 0 1 0",
                  bus.flit_valid, bus.pkt_ready, dbg_state);
      end
      rst = 1'b0;
      send_pkt(5'd2, 4'h2, rand_data());
      n_cmp++;
      if (bus.flit_out[14:8] !== 7'd0 || bus.flit_out[3:0] !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_restart: got pid=%0d seq=%0d want 0 0", bus.flit_out[14:8],
                  bus.flit_out[3:0]);
      end
      wait_idle();
   endtask

   task automatic test_pid_wrap();
      bus.flit_ready = 1'b1;
      for (int i = 0; i < 130; i++) begin
         send_pkt(5'd1, 4'($urandom_range(0, 15)), rand_data());
         n_cmp++;
         if (bus.flit_out[14:8] !== 7'(i)) begin
            n_fail++;
            $display("FAIL pid_wrap%0d: got %0d want %0d", i, bus.flit_out[14:8], 7'(i));
         end
      end
      wait_idle();
   endtask

   initial begin
      bus.pkt_valid  = 1'b0;
      bus.pkt_len    = '0;
      bus.pkt_dest   = '0;
      bus.pkt_data   = '0;
      bus.flit_ready = 1'b1;
      test_reset();
      test_basic();
      test_stall();
      test_len_err();
      test_epoch_cross();
      test_back_to_back();
      test_reset_mid_packet();
      test_reset();
      test_pid_wrap();
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_queue: got %0d pending want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got no finish within 20000 cycles");
      $fatal(1, "watchdog");
   end

endmodule
